// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encodings and the halt-syscall constants used upstream.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    STATE_RUN    = 2'd0,
    STATE_DRAIN  = 2'd1,
    STATE_HALTED = 2'd2
  } state_t;

  // ecall with a7 (x17) == 10 requests a halt; decoded in EX upstream.
  localparam logic [31:0] HALT_SYSCALL_ID = 32'd10;
  localparam logic [4:0]  HALT_REG_IDX    = 5'd17;

  // True when a drain counter value is the last drain cycle.
  function automatic logic drain_last(input int unsigned cnt, input int unsigned drain_cycles);
    return (cnt == (drain_cycles - 32'd1));
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/cache inputs and per-stage control outputs of the stall controller.
// master = pipeline side (drives hazards/readies), slave = controller.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic             is_hazard;
  logic             halt_req;
  logic             mispredict;
  logic             icache_ready;
  logic             dcache_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_freeze;
  logic             is_halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output is_hazard, halt_req, mispredict, icache_ready, dcache_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze,
           is_halted, stall_cycles, flush_count
  );

  modport slave (
    input  is_hazard, halt_req, mispredict, icache_ready, dcache_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze,
           is_halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller_perf_counter.sv
// Free-running wrap-around event counter with synchronous active-low reset.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count enabled events; wraps naturally modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges hazard, mispredict, cache-ready and
// halt requests into per-stage write-enable/flush controls, runs the halt
// drain FSM and keeps stall/flush performance counters.
module pipeline_stall_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  pipeline_stall_controller_if.slave  bus
);
  import pipeline_stall_controller_pkg::*;

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t             state_r, next_state_s;
  logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_next_s;
  logic               is_halted_r;

  logic pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s, pipe_freeze_s;
  logic stall_en_s, flush_en_s;

  // State register, drain counter and registered halted flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= STATE_RUN;
      drain_cnt_r <= {DRAIN_W{1'b0}};
      is_halted_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      drain_cnt_r <= drain_cnt_next_s;
      is_halted_r <= (next_state_s == STATE_HALTED);
    end
  end

  // Next-state logic; a D-cache stall masks the halt request in RUN.
  always_comb begin
    next_state_s     = state_r;
    drain_cnt_next_s = drain_cnt_r;
    case (state_r)
      STATE_RUN: begin
        if (bus.dcache_ready && bus.halt_req) begin
          next_state_s     = STATE_DRAIN;
          drain_cnt_next_s = {DRAIN_W{1'b0}};
        end else begin
          next_state_s = STATE_RUN;
        end
      end
      STATE_DRAIN: begin
        if (!bus.dcache_ready) begin
          next_state_s = STATE_DRAIN;
        end else if (drain_last(32'(drain_cnt_r), 32'(DRAIN_CYCLES))) begin
          next_state_s = STATE_HALTED;
        end else begin
          drain_cnt_next_s = drain_cnt_r + {{(DRAIN_W-1){1'b0}}, 1'b1};
        end
      end
      STATE_HALTED: begin
        next_state_s = STATE_HALTED;
      end
      default: begin
        next_state_s     = STATE_RUN;
        drain_cnt_next_s = {DRAIN_W{1'b0}};
      end
    endcase
  end

  // Output decode: reset bubble, RUN priority chain, drain and halted holds.
  always_comb begin
    pc_write_s    = 1'b0;
    if_id_write_s = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    pipe_freeze_s = 1'b0;
    stall_en_s    = 1'b0;
    flush_en_s    = 1'b0;
    if (!reset) begin
      if_id_write_s = 1'b0;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else begin
      case (state_r)
        STATE_RUN: begin
          if (!bus.dcache_ready) begin
            pipe_freeze_s = 1'b1;
            if_id_write_s = 1'b0;
          end else if (bus.halt_req) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else if (bus.mispredict) begin
            pc_write_s    = 1'b1;
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            flush_en_s    = 1'b1;
          end else if (bus.is_hazard) begin
            if_id_write_s = 1'b0;
            id_ex_flush_s = 1'b1;
          end else if (!bus.icache_ready) begin
            if_id_flush_s = 1'b1;
          end else begin
            pc_write_s = 1'b1;
          end
          stall_en_s = !pc_write_s;
        end
        STATE_DRAIN: begin
          if_id_write_s = 1'b0;
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
          pipe_freeze_s = !bus.dcache_ready;
        end
        STATE_HALTED: begin
          if_id_write_s = 1'b0;
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
          pipe_freeze_s = 1'b1;
        end
        default: begin
          if_id_write_s = 1'b0;
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write    = pc_write_s;
  assign bus.if_id_write = if_id_write_s;
  assign bus.if_id_flush = if_id_flush_s;
  assign bus.id_ex_flush = id_ex_flush_s;
  assign bus.pipe_freeze = pipe_freeze_s;
  assign bus.is_halted   = is_halted_r & reset;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en_s),
    .count (bus.stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_en_s),
    .count (bus.flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller.
// Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, is_halted}.
module tb_pipeline_stall_controller;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  pipeline_stall_controller_if #(.CNT_W(32)) bus ();

  pipeline_stall_controller #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [5:0] ctl;
  assign ctl = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_flush, bus.pipe_freeze, bus.is_halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.is_hazard    = 1'b0;
    bus.halt_req     = 1'b0;
    bus.mispredict   = 1'b0;
    bus.icache_ready = 1'b1;
    bus.dcache_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic chk_ctl(input string name, input logic [5:0] exp);
    total_cnt++;
    if (ctl !== exp) $display("FAIL %s ctl got %b exp %b", name, ctl, exp);
    else pass_cnt++;
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got %0d exp %0d", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    chk_ctl("reset_forced", 6'b001100);
    step();
    chk_ctl("reset_forced_edge", 6'b001100);
    step();
    reset = 1'b1;
    #1;
    chk_ctl("run_idle_first", 6'b110000);
    repeat (10) step();
    chk_ctl("run_idle_10", 6'b110000);
    chk_cnt("idle_stall_cycles", bus.stall_cycles, 32'd0);
    chk_cnt("idle_flush_count", bus.flush_count, 32'd0);
  endtask

  task automatic test_icache_miss();
    do_reset(1);
    bus.icache_ready = 1'b0;
    #1;
    chk_ctl("icache_miss", 6'b011000);
    step();
    bus.icache_ready = 1'b1;
    #1;
    chk_ctl("icache_recover", 6'b110000);
    chk_cnt("icache_stall_cycles", bus.stall_cycles, 32'd1);
  endtask

  task automatic test_load_use();
    do_reset(2);
    bus.is_hazard = 1'b1;
    #1;
    chk_ctl("load_use", 6'b000100);
    step();
    bus.is_hazard = 1'b0;
    #1;
    chk_ctl("load_use_after", 6'b110000);
    chk_cnt("load_use_stall_cycles", bus.stall_cycles, 32'd1);
  endtask

  task automatic test_mispredict_hazard();
    do_reset(2);
    bus.mispredict = 1'b1;
    bus.is_hazard  = 1'b1;
    #1;
    chk_ctl("mispredict_hazard", 6'b111100);
    step();
    idle_inputs();
    #1;
    chk_cnt("mispredict_flush_count", bus.flush_count, 32'd1);
    chk_cnt("mispredict_stall_cycles", bus.stall_cycles, 32'd0);
  endtask

  task automatic test_dcache_mask();
    do_reset(2);
    bus.mispredict   = 1'b1;
    bus.dcache_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ctl($sformatf("dcache_freeze_%0d", i), 6'b000010);
      step();
    end
    chk_cnt("dcache_no_flush_yet", bus.flush_count, 32'd0);
    bus.dcache_ready = 1'b1;
    #1;
    chk_ctl("dcache_flush_5th", 6'b111100);
    step();
    idle_inputs();
    #1;
    chk_cnt("dcache_flush_count", bus.flush_count, 32'd1);
    chk_cnt("dcache_stall_cycles", bus.stall_cycles, 32'd4);
  endtask

  task automatic test_halt_drain();
    do_reset(2);
    bus.halt_req = 1'b1;
    #1;
    chk_ctl("halt_cycle", 6'b011100);
    step();
    bus.halt_req   = 1'b0;
    bus.mispredict = 1'b1;
    #1;
    chk_ctl("drain_1", 6'b001100);
    step();
    bus.dcache_ready = 1'b0;
    #1;
    chk_ctl("drain_2_frozen", 6'b001110);
    step();
    bus.dcache_ready = 1'b1;
    #1;
    chk_ctl("drain_3", 6'b001100);
    step();
    chk_ctl("drain_4_last", 6'b001100);
    step();
    chk_ctl("halted_5", 6'b001111);
    bus.is_hazard    = 1'b1;
    bus.icache_ready = 1'b0;
    repeat (3) step();
    chk_ctl("halted_hold", 6'b001111);
    chk_cnt("halt_stall_cycles", bus.stall_cycles, 32'd1);
    chk_cnt("halt_flush_count", bus.flush_count, 32'd0);
  endtask

  task automatic test_reset_halted();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk_ctl("reset_in_halted", 6'b001100);
    step();
    reset = 1'b1;
    #1;
    chk_ctl("run_after_halt_reset", 6'b110000);
    chk_cnt("reset_halt_stall_cycles", bus.stall_cycles, 32'd0);
    chk_cnt("reset_halt_flush_count", bus.flush_count, 32'd0);
  endtask

  task automatic test_reset_mid_drain();
    do_reset(1);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk_ctl("mid_drain_reset_run", 6'b110000);
    repeat (4) step();
    chk_ctl("mid_drain_reset_no_halt", 6'b110000);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    idle_inputs();
    test_reset();
    test_icache_miss();
    test_load_use();
    test_mispredict_hazard();
    test_dcache_mask();
    test_halt_drain();
    test_reset_halted();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
